// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with IF/ID pipeline register.
//
// Issues instruction-memory reads at pc, follows the branch predictor's
// next-PC, holds a skid buffer while ID stalls, and drains an in-flight
// request after a redirect so the memory handshake is never abandoned.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_readM, i_address    instruction-memory request (i_address == pc)
//   i_data, i_ready       instruction-memory response
//   pc                    current fetch PC, to the predictor
//   branch_predicted_pc   predictor next-PC for pc (combinational)
//   tag_match             predictor BTB hit for pc
//   stall                 ID hazard, IF/ID must hold
//   redirect, redirect_pc mispredict/jump correction
//   if_id_*               IF/ID register contents
//   fetch_count           instructions written into IF/ID (FETCH_COUNT_EN only)
//
// Optional feature macro: FETCH_COUNT_EN adds the fetch_count output.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module fetch_unit #(
    parameter logic [`WORD_SIZE-1:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  i_readM,
    output logic [`WORD_SIZE-1:0] i_address,
    input  logic [`WORD_SIZE-1:0] i_data,
    input  logic                  i_ready,
    output logic [`WORD_SIZE-1:0] pc,
    input  logic [`WORD_SIZE-1:0] branch_predicted_pc,
    input  logic                  tag_match,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [`WORD_SIZE-1:0] redirect_pc,
    output logic                  if_id_valid,
    output logic [`WORD_SIZE-1:0] if_id_inst,
    output logic [`WORD_SIZE-1:0] if_id_pc,
    output logic [`WORD_SIZE-1:0] if_id_pred_pc,
    output logic                  if_id_pred_taken
`ifdef FETCH_COUNT_EN
    ,
    output logic [`WORD_SIZE-1:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [`WORD_SIZE-1:0]   pc_d;
    logic [`WORD_SIZE-1:0]   pc_inc;
    logic                    pred_taken;

    logic [`WORD_SIZE-1:0]   skid_inst, skid_pc, skid_pred_pc;
    logic                    skid_taken;
    logic [`WORD_SIZE-1:0]   redir_pc_q;

    logic                    ifid_from_mem;
    logic                    ifid_from_skid;
    logic                    ifid_clear;
    logic                    skid_load;
    logic                    redir_load;

    assign i_address = pc;
    assign i_readM   = (state != HOLD);

    // 16-bit sum so 16'hFFFF + 1 wraps to 16'h0000 before the compare
    assign pc_inc     = pc + 16'd1;
    assign pred_taken = tag_match && (branch_predicted_pc != pc_inc);

    always_comb begin
        state_d        = state;
        pc_d           = pc;
        ifid_from_mem  = 1'b0;
        ifid_from_skid = 1'b0;
        ifid_clear     = 1'b0;
        skid_load      = 1'b0;
        redir_load     = 1'b0;

        unique case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    if (i_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        // request still outstanding: finish it before moving pc
                        redir_load = 1'b1;
                        state_d    = DRAIN;
                    end
                end else if (i_ready) begin
                    if (!stall) begin
                        ifid_from_mem = 1'b1;
                        pc_d          = branch_predicted_pc;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (!stall) begin
                    ifid_clear = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    pc_d       = redirect_pc;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ifid_from_skid = 1'b1;
                    pc_d           = skid_pred_pc;
                    state_d        = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    redir_load = 1'b1;
                end
                if (i_ready) begin
                    pc_d    = redirect ? redirect_pc : redir_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            if_id_valid      <= 1'b0;
            if_id_inst       <= '0;
            if_id_pc         <= '0;
            if_id_pred_pc    <= '0;
            if_id_pred_taken <= 1'b0;
            skid_inst        <= '0;
            skid_pc          <= '0;
            skid_pred_pc     <= '0;
            skid_taken       <= 1'b0;
            redir_pc_q       <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;

            if (ifid_from_mem) begin
                if_id_valid      <= 1'b1;
                if_id_inst       <= i_data;
                if_id_pc         <= pc;
                if_id_pred_pc    <= branch_predicted_pc;
                if_id_pred_taken <= pred_taken;
            end else if (ifid_from_skid) begin
                if_id_valid      <= 1'b1;
                if_id_inst       <= skid_inst;
                if_id_pc         <= skid_pc;
                if_id_pred_pc    <= skid_pred_pc;
                if_id_pred_taken <= skid_taken;
            end else if (ifid_clear) begin
                if_id_valid <= 1'b0;
            end

            if (skid_load) begin
                skid_inst    <= i_data;
                skid_pc      <= pc;
                skid_pred_pc <= branch_predicted_pc;
                skid_taken   <= pred_taken;
            end

            if (redir_load) begin
                redir_pc_q <= redirect_pc;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
        end else if (ifid_from_mem || ifid_from_skid) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Memory returns (address ^ 16'hA500); predictor returns pc+1 unless overridden.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] pc;
    logic [15:0] branch_predicted_pc;
    logic        tag_match;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pred_pc;
    logic        if_id_pred_taken;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    logic        bp_ovr;
    logic [15:0] bp_val;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign i_data              = i_address ^ 16'hA500;
    assign branch_predicted_pc = bp_ovr ? bp_val : (pc + 16'd1);

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_readM             (i_readM),
        .i_address           (i_address),
        .i_data              (i_data),
        .i_ready             (i_ready),
        .pc                  (pc),
        .branch_predicted_pc (branch_predicted_pc),
        .tag_match           (tag_match),
        .stall               (stall),
        .redirect            (redirect),
        .redirect_pc         (redirect_pc),
        .if_id_valid         (if_id_valid),
        .if_id_inst          (if_id_inst),
        .if_id_pc            (if_id_pc),
        .if_id_pred_pc       (if_id_pred_pc),
        .if_id_pred_taken    (if_id_pred_taken)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count         (fetch_count)
`endif
    );

    function automatic logic [15:0] inst_of(input logic [15:0] a);
        return a ^ 16'hA500;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        i_ready     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        tag_match   = 1'b0;
        bp_ovr      = 1'b0;
        bp_val      = 16'h0000;

        // reset values, no clock edge yet
        #3;
        chk("rst_pc",    pc, 16'h0000);
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_inst",  if_id_inst, 16'h0000);
        chk("rst_ipc",   if_id_pc, 16'h0000);
        chk("rst_pred",  if_id_pred_pc, 16'h0000);
        chk("rst_taken", {15'd0, if_id_pred_taken}, 16'd0);

        // release reset, single-cycle memory
        @(posedge clk); #1;
        reset_n = 1'b1;
        i_ready = 1'b1;
        chk("c1_addr",  i_address, 16'h0000);
        chk("c1_readM", {15'd0, i_readM}, 16'd1);
        chk("c1_valid", {15'd0, if_id_valid}, 16'd0);
        tick;
        chk("c2_addr",  i_address, 16'h0001);
        chk("c2_valid", {15'd0, if_id_valid}, 16'd1);
        chk("c2_ipc",   if_id_pc, 16'h0000);
        chk("c2_inst",  if_id_inst, inst_of(16'h0000));
        chk("c2_pred",  if_id_pred_pc, 16'h0001);
        chk("c2_taken", {15'd0, if_id_pred_taken}, 16'd0);
        tick;
        chk("c3_addr", i_address, 16'h0002);
        chk("c3_ipc",  if_id_pc, 16'h0001);
        tick;
        chk("c4_addr", i_address, 16'h0003);
        tick;
        tick;
        chk("c6_addr", i_address, 16'h0005);
        chk("c6_ipc",  if_id_pc, 16'h0004);

        // stall 3 cycles with response at pc=5
        stall = 1'b1;
        tick;
        chk("hold_readM", {15'd0, i_readM}, 16'd0);
        chk("hold_addr",  i_address, 16'h0005);
        chk("hold_ipc",   if_id_pc, 16'h0004);
        tick;
        tick;
        chk("hold3_readM", {15'd0, i_readM}, 16'd0);
        chk("hold3_ipc",   if_id_pc, 16'h0004);
        chk("hold3_valid", {15'd0, if_id_valid}, 16'd1);
        stall = 1'b0;
        tick;
        chk("rel_ipc",   if_id_pc, 16'h0005);
        chk("rel_inst",  if_id_inst, inst_of(16'h0005));
        chk("rel_addr",  i_address, 16'h0006);
        chk("rel_readM", {15'd0, i_readM}, 16'd1);
        tick;
        chk("rel2_ipc",  if_id_pc, 16'h0006);
        chk("rel2_addr", i_address, 16'h0007);
        tick;
        chk("rel3_ipc",  if_id_pc, 16'h0007);
        chk("rel3_addr", i_address, 16'h0008);

        // slow memory at pc=8, redirect to 0x0100 in first cycle of request
        i_ready     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick;
        chk("dr1_addr",  i_address, 16'h0008);
        chk("dr1_readM", {15'd0, i_readM}, 16'd1);
        chk("dr1_valid", {15'd0, if_id_valid}, 16'd0);
        redirect = 1'b0;
        tick;
        chk("dr2_addr",  i_address, 16'h0008);
        chk("dr2_valid", {15'd0, if_id_valid}, 16'd0);
        i_ready = 1'b1;
        tick;
        chk("dr3_addr",  i_address, 16'h0100);
        chk("dr3_valid", {15'd0, if_id_valid}, 16'd0);
        tick;
        chk("dr4_ipc",   if_id_pc, 16'h0100);
        chk("dr4_valid", {15'd0, if_id_valid}, 16'd1);
        chk("dr4_addr",  i_address, 16'h0101);

        // no response, no stall: bubble
        i_ready = 1'b0;
        tick;
        chk("bub_valid", {15'd0, if_id_valid}, 16'd0);
        chk("bub_addr",  i_address, 16'h0101);
        i_ready = 1'b1;

        // redirect with response in FETCH: data discarded
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick;
        chk("rf_addr",  i_address, 16'h0010);
        chk("rf_valid", {15'd0, if_id_valid}, 16'd0);
        redirect  = 1'b0;

        // predicted-taken branch at 0x0010 -> 0x0040
        bp_ovr    = 1'b1;
        bp_val    = 16'h0040;
        tag_match = 1'b1;
        tick;
        chk("br_ipc",   if_id_pc, 16'h0010);
        chk("br_pred",  if_id_pred_pc, 16'h0040);
        chk("br_taken", {15'd0, if_id_pred_taken}, 16'd1);
        chk("br_addr",  i_address, 16'h0040);
`ifdef FETCH_COUNT_EN
        chk("cnt10", fetch_count, 16'd10);
`endif
        // BTB hit that predicts fall-through is not taken
        bp_ovr = 1'b0;
        tick;
        chk("nt_ipc",   if_id_pc, 16'h0040);
        chk("nt_pred",  if_id_pred_pc, 16'h0041);
        chk("nt_taken", {15'd0, if_id_pred_taken}, 16'd0);

        // wrap: 0xFFFF + 1 = 0x0000 is still fall-through
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick;
        chk("wr_addr0", i_address, 16'hFFFF);
        redirect = 1'b0;
        tick;
        chk("wr_ipc",   if_id_pc, 16'hFFFF);
        chk("wr_pred",  if_id_pred_pc, 16'h0000);
        chk("wr_taken", {15'd0, if_id_pred_taken}, 16'd0);
        chk("wr_addr",  i_address, 16'h0000);
        tag_match = 1'b0;

        // enter HOLD at pc=0, then redirect + stall together
        stall = 1'b1;
        tick;
        chk("hr_readM", {15'd0, i_readM}, 16'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick;
        chk("hr_valid", {15'd0, if_id_valid}, 16'd0);
        chk("hr_addr",  i_address, 16'h0200);
        chk("hr_readM2", {15'd0, i_readM}, 16'd1);
        redirect = 1'b0;
        stall    = 1'b0;
        tick;
        chk("hr_ipc",   if_id_pc, 16'h0200);
        chk("hr_addr2", i_address, 16'h0201);

        // DRAIN with a second redirect overwriting the latched PC
        i_ready     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        tick;
        redirect_pc = 16'h0400;
        tick;
        chk("dw_addr", i_address, 16'h0201);
        redirect = 1'b0;
        i_ready  = 1'b1;
        tick;
        chk("dw_addr2", i_address, 16'h0400);
        chk("dw_valid", {15'd0, if_id_valid}, 16'd0);
        tick;
        chk("dw_ipc", if_id_pc, 16'h0400);

        // asynchronous reset in mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_pc",    pc, 16'h0000);
        chk("ar_valid", {15'd0, if_id_valid}, 16'd0);
        chk("ar_inst",  if_id_inst, 16'h0000);
`ifdef FETCH_COUNT_EN
        chk("ar_cnt", fetch_count, 16'd0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        // i_ready held high: stray response accepted for RESET_PC
        tick;
        chk("sr_valid", {15'd0, if_id_valid}, 16'd1);
        chk("sr_ipc",   if_id_pc, 16'h0000);
        chk("sr_inst",  if_id_inst, inst_of(16'h0000));
        chk("sr_addr",  i_address, 16'h0001);
`ifdef FETCH_COUNT_EN
        chk("sr_cnt", fetch_count, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
